// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard controller beside the ID stage. It is the only source of the
// PC write enable, the IF/ID stall/flush controls and the ID/EX bubble.
//
// It resolves four hazard sources, highest priority first:
//   1. data-memory wait (mem_stall_i): freeze the front end. No bubble is
//      inserted. The multiply FSM is frozen.
//   2. multiply in progress (MUL_BUSY with cnt != 0): stall and bubble.
//   3. multiply detected in ID while IDLE: stall and bubble, then arm the
//      countdown.
//   4. load-use hazard against the load in EX: a single combinational stall
//      and bubble.
// A taken branch flushes IF/ID only when no stall is active. The branch is
// seen again once the stall releases.
//
// Parameters:
//   MUL_LAT          total stall cycles charged to a multiply (legal 1..15)
//
// Ports:
//   clk_i            core clock; all state changes on the rising edge
//   rst_i            synchronous active-high reset
//   id_rs1_i         rs1 address of the instruction in ID
//   id_rs2_i         rs2 address of the instruction in ID
//   id_mul_i         the instruction in ID is a multiply
//   branch_taken_i   branch resolved taken in ID this cycle
//   ex_memread_i     the instruction in EX is a load
//   ex_rd_i          destination register of the instruction in EX
//   mem_stall_i      data memory not ready
//   pc_write_o       PC register update enable
//   if_id_stall_o    hold IF/ID contents
//   if_id_flush_o    zero IF/ID contents
//   id_ex_bubble_o   load a NOP into ID/EX
//   dbg_state_o      current FSM state (0 = IDLE, 1 = MUL_BUSY)
//   dbg_cnt_o        current multiply countdown value
//
// Optional feature (macro HAZARD_PERF_CNT_EN):
//   stall_cycles_o   number of cycles with if_id_stall_o = 1
//   flush_count_o    number of cycles with if_id_flush_o = 1
//   Both counters saturate at 0xFFFFFFFF and are cleared by rst_i.
//   When the macro is undefined, these ports and counters do not exist.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int MUL_LAT = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        id_mul_i,
  input  logic        branch_taken_i,
  input  logic        ex_memread_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        mem_stall_i,
  output logic        pc_write_o,
  output logic        if_id_stall_o,
  output logic        if_id_flush_o,
  output logic        id_ex_bubble_o,
  output logic        dbg_state_o,
  output logic [3:0]  dbg_cnt_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles_o,
  output logic [31:0] flush_count_o
`endif
);

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MUL_BUSY = 1'b1
  } state_t;

  // This value is loaded into the countdown when a multiply is accepted.
  // The detect cycle is itself one stall, so MUL_LAT-1 busy cycles remain.
  localparam logic [3:0] LP_CNT_LOAD = 4'(MUL_LAT - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;

  logic w_load_use;
  logic w_busy_stall;
  logic w_mul_detect;
  logic w_hazard_stall;

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  // x0 is never a real dependency, because a load targeting it writes nothing.
  assign w_load_use = ex_memread_i && (ex_rd_i != 5'd0) &&
                      ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));

  // In the release cycle (MUL_BUSY with cnt == 0), the multiply no longer
  // stalls and id_mul_i is ignored. The multiply in ID is the one that just
  // completed, so it must not be accepted a second time.
  assign w_busy_stall = (r_state == ST_MUL_BUSY) && (r_cnt != 4'd0);
  assign w_mul_detect = (r_state == ST_IDLE) && id_mul_i;

  // A multiply detected in the same cycle as a load-use hazard produces a
  // single combined stall. The FSM still arms the countdown.
  assign w_hazard_stall = w_busy_stall || w_mul_detect || w_load_use;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    pc_write_o     = 1'b1;
    if_id_stall_o  = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_bubble_o = 1'b0;

    if (rst_i) begin
      // While reset is asserted, keep the idle output values. The register
      // block handles the state clear.
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = 4'd0;
    end else if (mem_stall_i) begin
      // Freeze the whole front end. The instruction in ID stays there, so no
      // bubble is needed. The FSM holds its state, so memory wait cycles add
      // to the multiply stall count and do not replace any of it.
      pc_write_o    = 1'b0;
      if_id_stall_o = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (id_mul_i) begin
            w_state_nxt = ST_MUL_BUSY;
            w_cnt_nxt   = LP_CNT_LOAD;
          end
        end
        ST_MUL_BUSY: begin
          if (r_cnt != 4'd0) begin
            w_cnt_nxt = r_cnt - 4'd1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 4'd0;
        end
      endcase

      if (w_hazard_stall) begin
        pc_write_o     = 1'b0;
        if_id_stall_o  = 1'b1;
        id_ex_bubble_o = 1'b1;
      end else if (branch_taken_i) begin
        // A flush happens only when nothing is held. A stalled branch stays
        // in ID and resolves again after the stall releases.
        if_id_flush_o = 1'b1;
      end
    end
  end

  assign dbg_state_o = r_state;
  assign dbg_cnt_o   = r_cnt;

`ifdef HAZARD_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_count;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cycles <= 32'd0;
      r_flush_count  <= 32'd0;
    end else begin
      if (if_id_stall_o && (r_stall_cycles != 32'hFFFF_FFFF)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (if_id_flush_o && (r_flush_count != 32'hFFFF_FFFF)) begin
        r_flush_count <= r_flush_count + 32'd1;
      end
    end
  end

  assign stall_cycles_o = r_stall_cycles;
  assign flush_count_o  = r_flush_count;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Self-checking bench for hazard_ctrl. Directed sequences exercise the
// documented cases first. Randomized traffic then follows. A reference model
// predicts every cycle, and its predictions go through an expected queue.
//
// The model tracks each multiply as a count of stall cycles it has already
// been charged. While the count is below MUL_LAT, the multiply stalls. When
// the count reaches MUL_LAT, the next non-memory-stalled cycle is the release
// cycle.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int MUL_LAT = 3;

  // ---------------------------------------------------------------------------
  // Clock and reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_mul, branch_taken, ex_memread, mem_stall;
  logic       pc_write, if_id_stall, if_id_flush, id_ex_bubble;
  logic       dbg_state;
  logic [3:0] dbg_cnt;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  hazard_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .id_rs1_i       (id_rs1),
    .id_rs2_i       (id_rs2),
    .id_mul_i       (id_mul),
    .branch_taken_i (branch_taken),
    .ex_memread_i   (ex_memread),
    .ex_rd_i        (ex_rd),
    .mem_stall_i    (mem_stall),
    .pc_write_o     (pc_write),
    .if_id_stall_o  (if_id_stall),
    .if_id_flush_o  (if_id_flush),
    .id_ex_bubble_o (id_ex_bubble),
    .dbg_state_o    (dbg_state),
    .dbg_cnt_o      (dbg_cnt)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles_o (stall_cycles),
    .flush_count_o  (flush_count)
`endif
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state and reference model
  // ---------------------------------------------------------------------------
  // Each expected vector is {pc_write, stall, flush, bubble, busy}.
  logic [4:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // A value of -1 means no multiply is in flight. Any other value is the
  // number of stall cycles charged so far.
  int          m_mul = -1;
  int unsigned m_stall_cnt = 0;
  int unsigned m_flush_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: apply one cycle of inputs, predict, sample at negedge, compare
  // ---------------------------------------------------------------------------
  task automatic step(input logic r, input logic mul, input logic br,
                      input logic mr, input logic ms, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [4:0] rd,
                      output logic [4:0] obs);
    logic       lu, mstall, st, busy;
    logic [4:0] e, got;
    logic [3:0] e_cnt;
    int         nxt;

    rst = r; id_mul = mul; branch_taken = br; ex_memread = mr;
    mem_stall = ms; id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd;

    lu     = mr && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
    busy   = (m_mul >= 0);
    e_cnt  = busy ? 4'(MUL_LAT - m_mul) : 4'd0;
    nxt    = m_mul;
    mstall = 1'b0;
    if (r) begin
      e   = {1'b1, 1'b0, 1'b0, 1'b0, busy};
      nxt = -1;
    end else if (ms) begin
      e = {1'b0, 1'b1, 1'b0, 1'b0, busy};
    end else begin
      if (m_mul < 0) begin
        if (mul) begin mstall = 1'b1; nxt = 1; end
      end else if (m_mul < MUL_LAT) begin
        mstall = 1'b1; nxt = m_mul + 1;
      end else begin
        nxt = -1;
      end
      st = mstall || lu;
      e  = {!st, st, br && !st, st, busy};
    end
    exp_q.push_back(e);

    @(negedge clk);
    got = {pc_write, if_id_stall, if_id_flush, id_ex_bubble, dbg_state};
    chk("outputs", 32'(got), 32'(exp_q.pop_front()));
    chk("cnt", 32'(dbg_cnt), 32'(e_cnt));
`ifdef HAZARD_PERF_CNT_EN
    chk("stall_cycles", stall_cycles, m_stall_cnt);
    chk("flush_count", flush_count, m_flush_cnt);
`endif
    obs = got;

    m_mul = nxt;
    if (r) begin
      m_stall_cnt = 0;
      m_flush_cnt = 0;
    end else begin
      if (e[3] && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
      if (e[2] && m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_step(output logic [4:0] obs);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0, obs);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [4:0] o;
    int         nstall;

    rst = 1'b1; id_mul = 1'b0; branch_taken = 1'b0; ex_memread = 1'b0;
    mem_stall = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    repeat (2) @(posedge clk);
    #1;

    // The first reset cycle is checked like any other cycle.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, o);
    chk("reset_out", 32'(o), 32'b10000);

    // Load-use hazard: a one-cycle stall, after which all outputs are clear.
    // A load whose destination is x0 causes no stall.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 5'd5, 5'd5, o);
    chk("lu_stall", 32'(o), 32'b01010);
    idle_step(o);
    chk("lu_clear", 32'(o), 32'b10000);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, o);
    chk("lu_x0", 32'(o), 32'b10000);

    // Multiply held in ID: stalls on cycles 0, 1 and 2, then a release cycle.
    nstall = 0;
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0, o);
      if (o[3]) nstall++;
      if (c == 0) chk("mul_detect", 32'(o), 32'b01010);
      if (c == 3) chk("mul_release", 32'(o), 32'b10001);
    end
    chk("mul_stall_total", 32'(nstall), 32'(MUL_LAT));
    idle_step(o);
    chk("mul_idle", 32'(o), 32'b10000);

    // Two memory stall cycles during MUL_BUSY give five stall cycles in total.
    nstall = 0;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0, o); if (o[3]) nstall++;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0, o); if (o[3]) nstall++;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd0, o); if (o[3]) nstall++;
    chk("memstall_nobubble", 32'(o), 32'b01001);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd0, o); if (o[3]) nstall++;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0, o); if (o[3]) nstall++;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0, o);
    chk("memstall_release", 32'(o), 32'b10001);
    chk("memstall_total", 32'(nstall), 32'd5);

    // A taken branch alone flushes. A simultaneous load-use hazard suppresses
    // the flush.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0, o);
    chk("branch_flush", 32'(o), 32'b10100);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd7, 5'd2, 5'd7, o);
    chk("branch_vs_lu", 32'(o), 32'b01010);

    // Reset asserted while MUL_BUSY holds cnt = 1.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0, o);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0, o);
    chk("pre_rst_cnt", 32'(dbg_cnt), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0, o);
    chk("rst_forced", 32'(o), 32'b10001);
    idle_step(o);
    chk("rst_mid_mul", 32'(o), 32'b10000);
`ifdef HAZARD_PERF_CNT_EN
    chk("rst_stall_cnt", stall_cycles, 32'd0);
    chk("rst_flush_cnt", flush_count, 32'd0);
    // Four load-use stalls and two flushes.
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4, 5'd6, 5'd4, o);
      idle_step(o);
    end
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0, o);
      idle_step(o);
    end
    chk("perf_stall4", stall_cycles, 32'd4);
    chk("perf_flush2", flush_count, 32'd2);
`endif

    // Randomized traffic. Small register numbers make load-use hits frequent.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 2),
           ($urandom_range(0, 99) < 20),
           ($urandom_range(0, 99) < 30),
           ($urandom_range(0, 99) < 30),
           ($urandom_range(0, 99) < 15),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), o);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Overall time limit, so that a stuck run still ends with a report.
  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller that drives the stall/flush side of the IF/ID pipeline register and the bubble input of ID/EX. It detects load-use hazards, sequences multi-cycle multiply stalls with a countdown FSM, propagates data-memory wait stalls, and issues branch flushes. It sits beside the ID stage and is the sole source of `pc_write`, IF/ID stall/flush and ID/EX bubble in the core.

## Interface
- `MUL_LAT`, 3, total stall cycles charged to a multiply in ID (legal 1..15)
- `clk_i`  in  1  core clock, all state on rising edge
- `rst_i`  in  1  reset, synchronous, active-high
- `id_rs1_i`  in  5  rs1 address of instruction in ID
- `id_rs2_i`  in  5  rs2 address of instruction in ID
- `id_mul_i`  in  1  instruction in ID is a multiply
- `branch_taken_i`  in  1  branch resolved taken in ID this cycle
- `ex_memread_i`  in  1  instruction in EX is a load
- `ex_rd_i`  in  5  destination register of instruction in EX
- `mem_stall_i`  in  1  data memory not ready; freeze whole front end
- `pc_write_o`  out  1  PC register update enable
- `if_id_stall_o`  out  1  hold IF/ID contents
- `if_id_flush_o`  out  1  zero IF/ID contents
- `id_ex_bubble_o`  out  1  load NOP into ID/EX

## Operation
- FSM states: IDLE, MUL_BUSY; 4-bit down-counter `cnt`.
- Priority, highest first: mem_stall > MUL_BUSY (cnt≠0) > mul detect in IDLE > load-use > branch flush.
- mem_stall_i=1: pc_write_o=0, if_id_stall_o=1, id_ex_bubble_o=0, if_id_flush_o=0; FSM state and cnt frozen.
- Mul detect (IDLE, id_mul_i=1): stall (pc_write_o=0, if_id_stall_o=1, id_ex_bubble_o=1); next state MUL_BUSY, cnt←MUL_LAT-1.
- MUL_BUSY, cnt≠0: same stall outputs; cnt←cnt-1.
- MUL_BUSY, cnt=0: release cycle; no mul stall, id_mul_i ignored; next state IDLE. Load-use and branch rules still evaluated this cycle.
- Load-use: ex_memread_i=1, ex_rd_i≠0, ex_rd_i equals id_rs1_i or id_rs2_i → stall outputs as above for that cycle only (combinational, no state).
- Branch flush: branch_taken_i=1 and no stall condition active → if_id_flush_o=1, pc_write_o=1. Suppressed whenever if_id_stall_o=1 (branch re-asserts once released).
- No condition: pc_write_o=1, other outputs 0.
- Outputs are combinational from state and inputs; only FSM/cnt/(perf counters) are registered.

## Timing
- rst_i=1 at edge: state←IDLE, cnt←0, perf counters←0. While rst_i=1 outputs forced: pc_write_o=1, if_id_stall_o=0, if_id_flush_o=0, id_ex_bubble_o=0.
- Reset mid-multiply: FSM returns to IDLE next edge, no residual stall.
- Load-use: exactly 1 stall cycle, zero-latency (same cycle as detect).
- Multiply: exactly MUL_LAT stall cycles (detect cycle + MUL_LAT-1 BUSY cycles), then one release cycle; mem stall cycles in between add to, never replace, that count.
- MUL_LAT=1: detect cycle stalls, next cycle is release.
- mul and load-use in same cycle: single combined stall; FSM still loads cnt.

## Configuration
- `HAZARD_PERF_CNT_EN` defined: adds outputs `stall_cycles_o` (32) counting cycles with if_id_stall_o=1, and `flush_count_o` (32) counting cycles with if_id_flush_o=1; both saturate at 0xFFFFFFFF, cleared by rst_i.
- Not defined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Load-use: ex_memread_i=1, ex_rd_i=5, id_rs2_i=5 for one cycle → that cycle pc_write_o=0, if_id_stall_o=1, id_ex_bubble_o=1; next cycle (memread dropped) all clear. ex_rd_i=0 → no stall.
- Multiply, MUL_LAT=3: id_mul_i held high → stall on cycles 0,1,2, release cycle 3 with pc_write_o=1 despite id_mul_i=1, IDLE at cycle 4.
- mem_stall_i pulsed 2 cycles during MUL_BUSY → id_ex_bubble_o=0 those cycles, total stall 5 cycles, release follows.
- branch_taken_i=1 alone → if_id_flush_o=1, pc_write_o=1; with simultaneous load-use → if_id_flush_o=0, stall outputs only.
- rst_i asserted in MUL_BUSY cnt=1 → next cycle outputs idle values, no stall; with HAZARD_PERF_CNT_EN, counters read 0.
- HAZARD_PERF_CNT_EN: 4 load-use stalls + 2 flushes → stall_cycles_o=4, flush_count_o=2.
